ex_muldiv: RTL

- Iterative multi-cycle multiply/divide unit in the EX stage, running beside the single-cycle ALU.
- Executes MULT, MULTU, DIV, DIVU into the HI/LO register pair and services MTHI/MTLO writes.
- Drives busy so the pipeline holds the EX instruction while an operation runs.
- The ALU feeds HI/LO readback onto its pass-through path (F=12) in the same stage.

---
 rtl/ex_muldiv_if.sv | 17 +
 rtl/ex_muldiv.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_if.sv
// rtl/ex_muldiv_if.sv - request/result bundle between EX decode and the mul/div unit
interface ex_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, A, B, flush, input busy, done, hi, lo);
  modport slave  (input start, op, A, B, flush, output busy, done, hi, lo);
endinterface

// File: rtl/ex_muldiv.sv
// rtl/ex_muldiv.sv - iterative shift-add multiply / restoring divide into HI/LO
module ex_muldiv #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  ex_muldiv_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt;
  logic                 is_div;
  logic                 neg_q;
  logic                 neg_r;
  logic                 div_zero;
  logic [WIDTH-1:0]     a_raw;
  logic [WIDTH-1:0]     addend;
  logic [2*WIDTH-1:0]   acc;
  logic                 done_q;
  logic [WIDTH-1:0]     hi_q, lo_q;

  logic                 accept, mt_wr;
  logic                 signed_op, a_neg, b_neg;
  logic [WIDTH-1:0]     abs_a, abs_b;
  logic [WIDTH:0]       mul_sum, rem_sh, div_diff;
  logic [2*WIDTH-1:0]   mul_next, div_next, prod;
  logic [WIDTH-1:0]     res_hi, res_lo;

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    mt_wr   = 1'b0;
    if (bus.flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            if (bus.op <= OP_DIVU) begin
              accept  = 1'b1;
              state_d = CALC;
            end else if (bus.op == OP_MTHI || bus.op == OP_MTLO) begin
              mt_wr = 1'b1;
            end
          end
        end
        CALC:    if (cnt == CNT_W'(WIDTH-1)) state_d = FIX;
        FIX:     state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    signed_op = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    a_neg     = signed_op & bus.A[WIDTH-1];
    b_neg     = signed_op & bus.B[WIDTH-1];
    abs_a     = a_neg ? -bus.A : bus.A;
    abs_b     = b_neg ? -bus.B : bus.B;
  end

  // Multiplier sits in acc[W-1:0] and shifts out LSB-first; the dividend
  // shifts out MSB-first into the partial remainder in acc[2W-1:W].
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? addend : '0)};
    mul_next = {mul_sum, acc[WIDTH-1:1]};
    rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff = rem_sh - {1'b0, addend};
    div_next = div_diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                               : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
  end

  always_comb begin
    prod = neg_q ? -acc : acc;
    if (!is_div) begin
      res_hi = prod[2*WIDTH-1:WIDTH];
      res_lo = prod[WIDTH-1:0];
    end else if (div_zero) begin
      res_hi = a_raw;
      res_lo = '1;
    end else begin
      res_hi = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
      res_lo = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      a_raw    <= '0;
      addend   <= '0;
      acc      <= '0;
    end else if (accept) begin
      cnt      <= '0;
      is_div   <= bus.op[1];
      neg_q    <= a_neg ^ b_neg;
      neg_r    <= a_neg;
      div_zero <= bus.op[1] && (bus.B == '0);
      a_raw    <= bus.A;
      addend   <= bus.op[1] ? abs_b : abs_a;
      acc      <= bus.op[1] ? {{WIDTH{1'b0}}, abs_a} : {{WIDTH{1'b0}}, abs_b};
    end else if (state_q == CALC && !bus.flush) begin
      cnt <= cnt + 1'b1;
      acc <= is_div ? div_next : mul_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      done_q <= 1'b0;
      if (!bus.flush && state_q == FIX) begin
        done_q <= 1'b1;
        hi_q   <= res_hi;
        lo_q   <= res_lo;
      end else if (mt_wr) begin
        if (bus.op == OP_MTHI) hi_q <= bus.A;
        else                   lo_q <= bus.A;
      end
    end
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule
